// File: rtl/trigger_generator.sv
// Programmable trigger pulse generator: start delay, pulse width, period and burst count.
// Optional TRIGGER_GENERATOR_EXT_START_EN adds a synchronized asynchronous ext_start input.
module trigger_generator #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             invert,
`ifdef TRIGGER_GENERATOR_EXT_START_EN
  input  logic             ext_start,
`endif
  input  logic [CNT_W-1:0] delay,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] burst,
  output logic             q,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulse_count
);

  typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_phaseCnt;
  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_lowLen;
  logic [CNT_W-1:0] r_burst;
  logic             r_inv;
  logic             r_q;
  logic             r_done;
  logic [CNT_W-1:0] r_pulseCount;

  logic             w_startReq;
  logic             w_accept;
  logic [CNT_W-1:0] w_effWidthIn;
  logic [CNT_W-1:0] w_lowLenIn;
  logic             w_phaseDone;
  logic             w_lastPulse;
  logic             w_enterHigh;
  logic             w_invSrc;
  logic             w_qNext;
  logic             w_doneNext;

`ifdef TRIGGER_GENERATOR_EXT_START_EN
  logic [1:0] r_extSync;
  logic       r_extPrev;
  logic       r_extPulse;

  // Two-flop synchronizer plus registered rising-edge detect: three clocks to acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_extSync  <= 2'b00;
      r_extPrev  <= 1'b0;
      r_extPulse <= 1'b0;
    end else begin
      r_extSync  <= {r_extSync[0], ext_start};
      r_extPrev  <= r_extSync[1];
      r_extPulse <= r_extSync[1] & ~r_extPrev;
    end
  end

  assign w_startReq = start | r_extPulse;
`else
  assign w_startReq = start;
`endif

  // Stop outranks start, so a simultaneous request in IDLE is dropped.
  assign w_accept     = (r_state == IDLE) && w_startReq && !stop;
  assign w_effWidthIn = (width == '0) ? CNT_W'(1) : width;
  assign w_lowLenIn   = (period > w_effWidthIn) ? (period - w_effWidthIn) : CNT_W'(1);
  assign w_phaseDone  = (r_phaseCnt == '0);
  assign w_lastPulse  = (r_burst != '0) && (r_pulseCount >= r_burst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_nextState = (delay == '0) ? HIGH : DELAY;
      end
      DELAY: begin
        if (stop)             w_nextState = IDLE;
        else if (w_phaseDone) w_nextState = HIGH;
      end
      HIGH: begin
        if (stop)             w_nextState = IDLE;
        else if (w_phaseDone) w_nextState = w_lastPulse ? IDLE : LOW;
      end
      LOW: begin
        if (stop)             w_nextState = IDLE;
        else if (w_phaseDone) w_nextState = HIGH;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // q is registered from the next state; IDLE tracks the live invert input.
  always_comb begin
    w_invSrc    = (r_state == IDLE) ? invert : r_inv;
    w_qNext     = (w_nextState == IDLE) ? invert : ((w_nextState == HIGH) ^ w_invSrc);
    w_doneNext  = (r_state == HIGH) && !stop && w_phaseDone && w_lastPulse;
    w_enterHigh = (w_nextState == HIGH) && (r_state != HIGH);
    busy        = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_width  <= '0;
      r_lowLen <= '0;
      r_burst  <= '0;
      r_inv    <= 1'b0;
    end else if (w_accept) begin
      r_width  <= w_effWidthIn;
      r_lowLen <= w_lowLenIn;
      r_burst  <= burst;
      r_inv    <= invert;
    end
  end

  // Phase counter holds remaining cycles minus one of the current DELAY/HIGH/LOW phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phaseCnt <= '0;
    end else if (w_nextState == IDLE) begin
      r_phaseCnt <= '0;
    end else if (w_accept) begin
      r_phaseCnt <= (delay == '0) ? (w_effWidthIn - CNT_W'(1)) : (delay - CNT_W'(1));
    end else if (w_enterHigh) begin
      r_phaseCnt <= r_width - CNT_W'(1);
    end else if ((r_state == HIGH) && (w_nextState == LOW)) begin
      r_phaseCnt <= r_lowLen - CNT_W'(1);
    end else begin
      r_phaseCnt <= r_phaseCnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q          <= 1'b0;
      r_done       <= 1'b0;
      r_pulseCount <= '0;
    end else begin
      r_q    <= w_qNext;
      r_done <= w_doneNext;
      if (w_accept)
        r_pulseCount <= CNT_W'(w_nextState == HIGH);
      else if (w_enterHigh && (r_pulseCount != '1))
        r_pulseCount <= r_pulseCount + CNT_W'(1);
    end
  end

  assign q           = r_q;
  assign done        = r_done;
  assign pulse_count = r_pulseCount;

endmodule

// File: tb/tb_trigger_generator.sv
// Directed table-driven bench for trigger_generator (CNT_W=8) plus multi-cycle corner sequences.
module tb_trigger_generator;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, stop, invert;
  logic             extStart;
  logic [CNT_W-1:0] delay, width, period, burst;
  logic             q, busy, done;
  logic [CNT_W-1:0] pulseCount;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic             start, stop, inv;
    logic [CNT_W-1:0] dly, wid, per, bur;
    logic             expQ, expBusy, expDone;
    logic [CNT_W-1:0] expCnt;
  } vec_t;

  vec_t vecs[15];

  trigger_generator #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .stop(stop),
    .invert(invert),
`ifdef TRIGGER_GENERATOR_EXT_START_EN
    .ext_start(extStart),
`endif
    .delay(delay),
    .width(width),
    .period(period),
    .burst(burst),
    .q(q),
    .busy(busy),
    .done(done),
    .pulse_count(pulseCount)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(logic s, logic p, logic i, int d, int w, int pe, int b,
                                 logic eq, logic eb, logic ed, int ec);
    vec_t v;
    v.start = s; v.stop = p; v.inv = i;
    v.dly = CNT_W'(d); v.wid = CNT_W'(w); v.per = CNT_W'(pe); v.bur = CNT_W'(b);
    v.expQ = eq; v.expBusy = eb; v.expDone = ed; v.expCnt = CNT_W'(ec);
    return v;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    start  = v.start;
    stop   = v.stop;
    invert = v.inv;
    delay  = v.dly;
    width  = v.wid;
    period = v.per;
    burst  = v.bur;
  endtask

  task automatic setParams(input logic s, input int d, input int w, input int pe, input int b);
    start  = s;
    delay  = CNT_W'(d);
    width  = CNT_W'(w);
    period = CNT_W'(pe);
    burst  = CNT_W'(b);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    // Burst of 3, delay 0, width 2, period 5; width change and a second start while busy are ignored.
    vecs[0]  = mkVec(1, 0, 0, 0, 2, 5, 3, 0, 0, 0, 0);
    vecs[1]  = mkVec(0, 0, 0, 0, 2, 5, 3, 1, 1, 0, 1);
    vecs[2]  = mkVec(0, 0, 0, 0, 7, 5, 3, 1, 1, 0, 1);
    vecs[3]  = mkVec(1, 0, 0, 0, 7, 9, 0, 0, 1, 0, 1);
    vecs[4]  = mkVec(0, 0, 0, 0, 7, 9, 0, 0, 1, 0, 1);
    vecs[5]  = mkVec(0, 0, 0, 0, 7, 9, 0, 0, 1, 0, 1);
    vecs[6]  = mkVec(0, 0, 0, 0, 7, 9, 0, 1, 1, 0, 2);
    vecs[7]  = mkVec(0, 0, 0, 0, 7, 9, 0, 1, 1, 0, 2);
    vecs[8]  = mkVec(0, 0, 0, 0, 7, 9, 0, 0, 1, 0, 2);
    vecs[9]  = mkVec(0, 0, 0, 0, 7, 9, 0, 0, 1, 0, 2);
    vecs[10] = mkVec(0, 0, 0, 0, 7, 9, 0, 0, 1, 0, 2);
    vecs[11] = mkVec(0, 0, 0, 0, 7, 9, 0, 1, 1, 0, 3);
    vecs[12] = mkVec(0, 0, 0, 0, 7, 9, 0, 1, 1, 0, 3);
    vecs[13] = mkVec(0, 0, 0, 0, 7, 9, 0, 0, 0, 1, 3);
    vecs[14] = mkVec(0, 0, 0, 0, 7, 9, 0, 0, 0, 0, 3);

    rst_n = 1'b0; extStart = 1'b0; stop = 1'b0; invert = 1'b0;
    setParams(0, 0, 0, 0, 0);
    #12;
    checkOutput("reset_q", 32'(q), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_done", 32'(done), 0);
    checkOutput("reset_count", 32'(pulseCount), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("post_reset_q", 32'(q), 0);
    invert = 1'b1;
    stepCycle();
    checkOutput("idle_invert_q", 32'(q), 1);
    invert = 1'b0;
    stepCycle();
    checkOutput("idle_noninvert_q", 32'(q), 0);

    for (int i = 0; i < 15; i++) begin
      checkOutput($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].expQ));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d_done", i), 32'(done), 32'(vecs[i].expDone));
      checkOutput($sformatf("vec%0d_count", i), 32'(pulseCount), 32'(vecs[i].expCnt));
      applyStimulus(vecs[i]);
      stepCycle();
    end
    start = 1'b0;

    // Start and stop together in IDLE: start discarded, count held.
    start = 1'b1; stop = 1'b1;
    setParams(1, 0, 2, 5, 1);
    stepCycle();
    start = 1'b0; stop = 1'b0;
    checkOutput("startstop_busy", 32'(busy), 0);
    checkOutput("startstop_count", 32'(pulseCount), 3);
    stepCycle();
    checkOutput("startstop_busy2", 32'(busy), 0);

    // Delay 4, width 1, period 1 forced to 2, burst 2; restart in the done cycle.
    setParams(1, 4, 1, 1, 2);
    for (int k = 1; k <= 8; k++) begin
      stepCycle();
      start = 1'b0;
      checkOutput($sformatf("d4_q_n%0d", k), 32'(q), 32'((k == 5) || (k == 7)));
      checkOutput($sformatf("d4_done_n%0d", k), 32'(done), 32'(k == 8));
    end
    checkOutput("d4_count", 32'(pulseCount), 2);
    checkOutput("d4_busy_end", 32'(busy), 0);
    setParams(1, 0, 1, 3, 1);
    stepCycle();
    start = 1'b0;
    checkOutput("restart_q", 32'(q), 1);
    checkOutput("restart_count", 32'(pulseCount), 1);
    stepCycle();
    checkOutput("restart_done", 32'(done), 1);
    checkOutput("restart_q_low", 32'(q), 0);

    // Inverted single pulse; invert input toggled mid-sequence must not matter.
    invert = 1'b1;
    stepCycle();
    checkOutput("inv_idle_q", 32'(q), 1);
    setParams(1, 0, 2, 5, 1);
    stepCycle();
    start = 1'b0;
    checkOutput("inv_n1_q", 32'(q), 0);
    invert = 1'b0;
    stepCycle();
    checkOutput("inv_n2_q", 32'(q), 0);
    invert = 1'b1;
    stepCycle();
    checkOutput("inv_n3_q", 32'(q), 1);
    checkOutput("inv_n3_done", 32'(done), 1);
    invert = 1'b0;
    stepCycle();

    // Continuous run, width 3 period 10, stopped mid-HIGH of pulse 5.
    setParams(1, 0, 3, 10, 0);
    for (int k = 1; k <= 42; k++) begin
      stepCycle();
      start = 1'b0;
    end
    checkOutput("cont_q_high", 32'(q), 1);
    checkOutput("cont_count", 32'(pulseCount), 5);
    stop = 1'b1;
    stepCycle();
    stop = 1'b0;
    checkOutput("stop_q", 32'(q), 0);
    checkOutput("stop_busy", 32'(busy), 0);
    checkOutput("stop_done", 32'(done), 0);
    checkOutput("stop_count", 32'(pulseCount), 5);
    stepCycle();
    checkOutput("stop_done2", 32'(done), 0);

    // Width 0 behaves as 1; continuous run saturates the pulse counter.
    setParams(1, 0, 0, 2, 0);
    stepCycle();
    start = 1'b0;
    checkOutput("w0_q1", 32'(q), 1);
    stepCycle();
    checkOutput("w0_q2", 32'(q), 0);
    stepCycle();
    checkOutput("w0_q3", 32'(q), 1);
    for (int k = 0; k < 600; k++) stepCycle();
    checkOutput("sat_count", 32'(pulseCount), 255);
    checkOutput("sat_busy", 32'(busy), 1);
    stop = 1'b1;
    stepCycle();
    stop = 1'b0;
    checkOutput("sat_stop_busy", 32'(busy), 0);
    checkOutput("sat_hold_count", 32'(pulseCount), 255);

    // Asynchronous reset during the LOW phase of an inverted sequence.
    invert = 1'b1;
    setParams(1, 0, 1, 10, 0);
    stepCycle();
    start = 1'b0;
    stepCycle();
    checkOutput("pre_reset_low_q", 32'(q), 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_q", 32'(q), 0);
    checkOutput("async_reset_busy", 32'(busy), 0);
    checkOutput("async_reset_count", 32'(pulseCount), 0);
    @(negedge clk);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("release_q", 32'(q), 1);
    checkOutput("release_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trigger_generator.md
TRIGGER_GENERATOR -- requirements
Module: trigger_generator

Interface
REQ-001 Parameter CNT_W, default 32: width of the delay, width, period, burst and count fields.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  single-cycle request to begin a pulse sequence.
REQ-005 stop  input  1  abort the current sequence.
REQ-006 invert  input  1  output polarity; 1 = active-low pulses.
REQ-007 delay  input  CNT_W  clocks from start acceptance to the first pulse.
REQ-008 width  input  CNT_W  high time per pulse, in clocks.
REQ-009 period  input  CNT_W  rising-edge-to-rising-edge spacing, in clocks.
REQ-010 burst  input  CNT_W  number of pulses; 0 = continuous.
REQ-011 q  output  1  registered trigger output.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 done  output  1  one-cycle strobe when a finite burst completes.
REQ-014 pulse_count  output  CNT_W  pulses issued since the last accepted start.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, DELAY, HIGH, LOW.
REQ-016 start SHALL be accepted only in IDLE; in any other state it SHALL be ignored.
REQ-017 On acceptance, the block SHALL latch delay, width, period, burst and invert, and SHALL clear pulse_count.
REQ-018 Latched width 0 SHALL be treated as 1.
REQ-019 If latched period <= effective width, the block SHALL use period = width+1, giving at least one LOW cycle.
REQ-020 Accept in cycle N, delay 0: the FSM SHALL enter HIGH and q SHALL assert in cycle N+1.
REQ-021 Accept in cycle N, delay D>0: the FSM SHALL spend D cycles in DELAY and q SHALL assert in cycle N+1+D.
REQ-022 Every entry into HIGH SHALL increment pulse_count.
- pulse_count SHALL saturate at all-ones.
- pulse_count SHALL hold its value in IDLE.
REQ-023 HIGH SHALL last exactly width cycles; LOW SHALL last exactly period-width cycles, then the FSM SHALL return to HIGH.
REQ-024 With burst B>0, after the HIGH phase of pulse B the FSM SHALL go directly to IDLE (no LOW phase).
- done SHALL pulse for that one transition cycle.
REQ-025 With burst 0, the sequence SHALL run until stop.
REQ-026 stop in any non-IDLE state SHALL return the FSM to IDLE on the next edge.
- q SHALL go to the idle level on that same edge.
- done SHALL stay low.
REQ-027 stop and start asserted in the same IDLE cycle: stop SHALL win and start SHALL be discarded.
REQ-028 q SHALL equal (pulse active) XOR invert.
- Outside IDLE, the latched invert SHALL be used.
- In IDLE, the live invert input SHALL be used, registered.
REQ-029 Input changes after acceptance SHALL NOT affect the running sequence.
REQ-030 A new start SHALL be accepted in the first IDLE cycle after done.

Reset
REQ-031 While rst_n is low: state IDLE, q=0, busy=0, done=0, pulse_count=0, all latched fields 0.
REQ-032 Assertion of rst_n SHALL take effect immediately (asynchronous), including mid-sequence.
REQ-033 After release, q SHALL equal invert from the first clock edge onward.

Configuration
REQ-034 Macro TRIGGER_GENERATOR_EXT_START_EN, when defined, SHALL add port ext_start (input, 1).
- ext_start SHALL pass through a two-flop synchronizer.
- Its synchronized rising edge SHALL act exactly as start, including REQ-016 and REQ-027.
- Latency from ext_start rising to acceptance: 3 clocks.
REQ-035 When the macro is undefined, ext_start and its synchronizer SHALL NOT exist, and only start initiates sequences.

Verification
REQ-036 delay=0, width=2, period=5, burst=3, start at cycle 10 -> q high in cycles 11-12, 16-17, 21-22; done in cycle 23; pulse_count=3; busy low from 23.
REQ-037 delay=4, width=1, period=1, burst=2 -> period forced to 2; q high in cycles N+5 and N+7; done in N+8.
REQ-038 burst=0, width=3, period=10; stop after 5 pulses, asserted mid-HIGH -> q low on the next edge; done stays 0; pulse_count=5.
REQ-039 invert=1, width=2, burst=1 -> q idles high, goes low for 2 cycles, returns high; toggling invert mid-sequence has no effect.
REQ-040 start+stop in the same cycle, then start during busy -> first start discarded, second start ignored; pulse_count unchanged.
REQ-041 rst_n low mid-LOW phase -> q=0, busy=0 and pulse_count=0 immediately without a clock; with the macro defined, a 1-cycle ext_start pulse gives q rising 3+1+delay cycles later.
